// File: rtl/rs_output_sequencer.sv
// rs_output_sequencer: walks the 15 symbol positions of an RS(15,11) codeword
// from index 14 down to 0 and drives the back-end output mux. At each position
// the mux takes the raw symbol (IN1) or the corrected symbol (IN2). The choice
// comes from the error locations latched at START.
// Optional build macro: RS_SEQ_PARITY_STRIP_EN -- stream data symbols 14..4 only.
module rs_output_sequencer #(
  parameter int N_SYMBOLS = 15,
  parameter int K_SYMBOLS = 11,
  parameter int IDX_W     = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [1:0]       ERR_CNT,
  input  logic [IDX_W-1:0] ERR_LOC0,
  input  logic [IDX_W-1:0] ERR_LOC1,
  input  logic             READY,
  output logic [IDX_W-1:0] SYM_IDX,
  output logic [1:0]       MUX_CTRL,
  output logic             OUT_VALID,
  output logic             BUSY,
  output logic             DONE,
  output logic             UNCORR
);

`ifdef RS_SEQ_PARITY_STRIP_EN
  localparam bit STRIP = 1'b1;
`else
  localparam bit STRIP = 1'b0;
`endif

  // Lowest position streamed: 0 normally, first data symbol when parity is stripped
  localparam int               LAST_IDX = STRIP ? (N_SYMBOLS - K_SYMBOLS) : 0;
  localparam logic [IDX_W-1:0] IDX_FIRST = IDX_W'(N_SYMBOLS - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(LAST_IDX);

  localparam logic [1:0] MUX_RAW  = 2'b00;
  localparam logic [1:0] MUX_CORR = 2'b01;
  localparam logic [1:0] MUX_HOLD = 2'b10;

  typedef enum logic [1:0] {S_IDLE, S_STREAM, S_FLUSH} state_t;

  state_t           state, state_nxt;
  logic [1:0]       cnt;
  logic [IDX_W-1:0] loc0, loc1;
  logic             advance, last_adv, match;

  assign advance  = (state == S_STREAM) && READY;
  assign last_adv = advance && (SYM_IDX == IDX_LAST);

  // SYM_IDX only ranges over [IDX_LAST..14] while streaming. Locations above
  // 14, or in a stripped parity region, therefore can never equal it.
  assign match = ((cnt == 2'd1 || cnt == 2'd2) && loc0 == SYM_IDX) ||
                 ((cnt == 2'd2) && loc1 == SYM_IDX);

  // State register
  always_ff @(posedge CLK) begin
    if (RST) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic: START is only honoured from IDLE
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (START)    state_nxt = S_STREAM;
      S_STREAM: if (last_adv) state_nxt = S_FLUSH;
      S_FLUSH:                state_nxt = S_IDLE;
      default:                state_nxt = S_IDLE;
    endcase
  end

  // Mux control: select only on an advancing STREAM cycle, otherwise hold
  always_comb begin
    MUX_CTRL = MUX_HOLD;
    if (advance) MUX_CTRL = match ? MUX_CORR : MUX_RAW;
  end

  // Frame datapath: error-info latch, symbol index, and the status flags
  // registered in step with the mux output register
  always_ff @(posedge CLK) begin
    if (RST) begin
      SYM_IDX   <= '0;
      cnt       <= '0;
      loc0      <= '0;
      loc1      <= '0;
      OUT_VALID <= 1'b0;
      BUSY      <= 1'b0;
      DONE      <= 1'b0;
      UNCORR    <= 1'b0;
    end else begin
      OUT_VALID <= advance;
      DONE      <= last_adv;
      case (state)
        S_IDLE: begin
          if (START) begin
            cnt     <= ERR_CNT;
            loc0    <= ERR_LOC0;
            loc1    <= ERR_LOC1;
            SYM_IDX <= IDX_FIRST;
            BUSY    <= 1'b1;
            UNCORR  <= (ERR_CNT == 2'd3);
          end
        end
        S_STREAM: begin
          // Parks at 0 after the last symbol so the index never wraps
          if (advance) SYM_IDX <= last_adv ? '0 : SYM_IDX - IDX_W'(1);
        end
        S_FLUSH: BUSY <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule
